// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared state encoding and widths for the I2C target
package i2c_target_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int BYTE_W = 8;
  localparam int CNT_W = 4;
  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    WAIT_STOP
  } state_e;
endpackage

// File: rtl/i2c_target_if.sv
// i2c_target_if: memory-style register port between the I2C target and its register space
interface i2c_target_if;
  import i2c_target_pkg::*;
  logic [BYTE_W-1:0] addr;
  logic              wr_en;
  logic [BYTE_W-1:0] wr_data;
  logic              rd_en;
  logic [BYTE_W-1:0] rd_data;
  logic              busy;
  modport master (output addr, wr_en, wr_data, rd_en, busy, input rd_data);
  modport slave (input addr, wr_en, wr_data, rd_en, busy, output rd_data);
endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizer for one bus line plus single-cycle rise/fall pulses
module i2c_line_sync
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES:0] sync_q;
  // synchronizer stages followed by the edge-history register; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-1:0], d_i};
  end
  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
  assign fall_o = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target exposing an auto-incrementing 8-bit register space
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scl,
  inout  wire          sda,
  i2c_target_if.master reg_if
);
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] ptr_q, ptr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic sda_oe_q, sda_oe_d;
  logic busy_q, busy_d;
  logic wr_en_q, wr_en_d;
  logic rw_q, rw_d;
  logic rd_en;

  i2c_line_sync u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (scl),
    .q_o    (scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sda),
    .q_o    (sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;
  assign sda   = sda_oe_q ? 1'b0 : 1'bz;

  assign reg_if.addr    = ptr_q;
  assign reg_if.wr_en   = wr_en_q;
  assign reg_if.wr_data = wr_data_q;
  assign reg_if.rd_en   = rd_en;
  assign reg_if.busy    = busy_q;

  // state and datapath registers; everything returns to idle with sda released
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      wr_data_q <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      wr_data_q <= wr_data_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      rw_q      <= rw_d;
    end
  end

  // bus protocol: bits shift in on scl rise, sda_oe and state move on scl fall
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = wr_en_q ? ptr_q + 8'd1 : ptr_q;
    wr_data_d = wr_data_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    rw_d      = rw_q;
    rd_en     = 1'b0;
    if (scl_rise && (state_q == ADDR || state_q == PTR || state_q == WDATA)) begin
      shift_d = {shift_q[BYTE_W-2:0], sda_lvl};
      cnt_d   = cnt_q + 1'b1;
    end
    case (state_q)
      ADDR: if (scl_fall && cnt_q == 4'd8) begin
        state_d  = (shift_q[7:1] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
        sda_oe_d = shift_q[7:1] == TARGET_ADDR;
        busy_d   = shift_q[7:1] == TARGET_ADDR;
        rw_d     = shift_q[0];
      end
      ADDR_ACK: if (scl_fall) begin
        sda_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = PTR;
        rd_en    = rw_q;
      end
      PTR: if (scl_fall && cnt_q == 4'd8) begin
        ptr_d    = shift_q;
        state_d  = PTR_ACK;
        sda_oe_d = 1'b1;
      end
      PTR_ACK, WDATA_ACK: if (scl_fall) begin
        sda_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = WDATA;
      end
      WDATA: if (scl_fall && cnt_q == 4'd8) begin
        state_d   = WDATA_ACK;
        sda_oe_d  = 1'b1;
        wr_en_d   = 1'b1;
        wr_data_d = shift_q;
      end
      RDATA: if (scl_fall) begin
        state_d  = (cnt_q == 4'd7) ? RACK : RDATA;
        sda_oe_d = (cnt_q == 4'd7) ? 1'b0 : ~shift_q[BYTE_W-2];
        shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
        cnt_d    = cnt_q + 1'b1;
      end
      RACK: begin
        if (scl_rise && sda_lvl) state_d = WAIT_STOP;
        rd_en = scl_fall;
      end
      default: ;
    endcase
    // entering RDATA: fetch the byte, drive its MSB and advance the pointer
    if (rd_en) begin
      state_d  = RDATA;
      shift_d  = reg_if.rd_data;
      sda_oe_d = ~reg_if.rd_data[BYTE_W-1];
      cnt_d    = '0;
      ptr_d    = ptr_q + 8'd1;
    end
    if (start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end
    if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C controller with a scoreboard for the register port
module tb_i2c_target;
  import i2c_target_pkg::*;
  localparam int Q = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_r = 1'b1;
  logic sda_low = 1'b0;
  wire  sda;
  logic [7:0] mem [256];
  logic [15:0] exp_wr[$], got_wr[$];
  logic [7:0] exp_rd[$], got_rd[$], exp_rx[$];
  int n_cmp = 0;
  int n_err = 0;
  int low_cnt = 0;
  int busy_cnt = 0;

  i2c_target_if rif ();

  i2c_target #(.TARGET_ADDR(7'h42)) dut (
    .clk    (clk),
    .rst    (rst),
    .scl    (scl_r),
    .sda    (sda),
    .reg_if (rif)
  );

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;
  assign rif.rd_data = mem[rif.addr];

  always #5 clk = ~clk;

  // register-port monitor: log strobes and count target-driven lows and busy cycles
  always @(negedge clk) begin
    if (rif.wr_en) got_wr.push_back({rif.addr, rif.wr_data});
    if (rif.rd_en) got_rd.push_back(rif.addr);
    if (!sda_low && sda === 1'b0) low_cnt++;
    if (rif.busy) busy_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_low = 1'b1;
    wait_clk(2 * Q);
    scl_r = 1'b0;
  endtask

  task automatic i2c_rstart();
    wait_clk(Q);
    sda_low = 1'b0;
    wait_clk(Q);
    scl_r = 1'b1;
    wait_clk(Q);
    sda_low = 1'b1;
    wait_clk(Q);
    scl_r = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q);
    sda_low = 1'b1;
    wait_clk(Q);
    scl_r = 1'b1;
    wait_clk(2 * Q);
    sda_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    wait_clk(Q);
    sda_low = ~b;
    wait_clk(Q);
    scl_r = 1'b1;
    wait_clk(Q);
    s = sda;
    wait_clk(Q);
    scl_r = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
    xfer_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b, output logic ack_line);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, s);
      b[i] = s;
    end
    xfer_bit(~ack, ack_line);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL reset_sda got=%b exp=1", sda); end
    n_cmp++; if (rif.addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got=%h exp=00", rif.addr); end
    n_cmp++; if (rif.wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%b exp=0", rif.wr_en); end
    n_cmp++; if (rif.wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data got=%h exp=00", rif.wr_data); end
    n_cmp++; if (rif.rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got=%b exp=0", rif.rd_en); end
    n_cmp++; if (rif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", rif.busy); end
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] bytes [4] = '{8'h84, 8'h10, 8'hA5, 8'h3C};
    got_wr.delete();
    exp_wr.push_back({8'h10, 8'hA5});
    exp_wr.push_back({8'h11, 8'h3C});
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL write_ack%0d got=%b exp=1", i, ack); end
      if (i == 0) begin
        n_cmp++; if (rif.busy !== 1'b1) begin n_err++; $display("FAIL write_busy_on got=%b exp=1", rif.busy); end
      end
    end
    i2c_stop();
    n_cmp++; if (rif.busy !== 1'b0) begin n_err++; $display("FAIL write_busy_off got=%b exp=0", rif.busy); end
    n_cmp++; if (got_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL write_count got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && got_wr.size() > 0) begin
      logic [15:0] e, g;
      e = exp_wr.pop_front();
      g = got_wr.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL write_strobe got=%h exp=%h", g, e); end
    end
    exp_wr.delete();
  endtask

  task automatic test_read();
    logic ack, ln;
    logic [7:0] b;
    got_wr.delete();
    got_rd.delete();
    mem[8'h20] = 8'h5A;
    mem[8'h21] = 8'hC3;
    exp_rd.push_back(8'h20);
    exp_rd.push_back(8'h21);
    exp_rx.push_back(8'h5A);
    exp_rx.push_back(8'hC3);
    i2c_start();
    write_byte(8'h84, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL read_waddr_ack got=%b exp=1", ack); end
    write_byte(8'h20, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL read_ptr_ack got=%b exp=1", ack); end
    i2c_rstart();
    write_byte(8'h85, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL read_raddr_ack got=%b exp=1", ack); end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      read_byte(i == 0, b, ln);
      e = exp_rx.pop_front();
      n_cmp++; if (b !== e) begin n_err++; $display("FAIL read_byte%0d got=%h exp=%h", i, b, e); end
    end
    n_cmp++; if (ln !== 1'b1) begin n_err++; $display("FAIL read_nack_release got=%b exp=1", ln); end
    i2c_stop();
    n_cmp++; if (got_rd.size() != exp_rd.size()) begin n_err++; $display("FAIL read_count got=%0d exp=%0d", got_rd.size(), exp_rd.size()); end
    while (exp_rd.size() > 0 && got_rd.size() > 0) begin
      logic [7:0] e, g;
      e = exp_rd.pop_front();
      g = got_rd.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL read_strobe_addr got=%h exp=%h", g, e); end
    end
    exp_rd.delete();
    n_cmp++; if (got_wr.size() != 0) begin n_err++; $display("FAIL read_no_write got=%0d exp=0", got_wr.size()); end
  endtask

  task automatic test_mismatch();
    logic ack;
    int low0, busy0;
    got_wr.delete();
    low0 = low_cnt;
    busy0 = busy_cnt;
    i2c_start();
    write_byte(8'h86, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL mismatch_no_ack got=%b exp=0", ack); end
    write_byte(8'h10, ack);
    write_byte(8'hFF, ack);
    i2c_stop();
    n_cmp++; if (low_cnt != low0) begin n_err++; $display("FAIL mismatch_sda_driven got=%0d exp=0", low_cnt - low0); end
    n_cmp++; if (busy_cnt != busy0) begin n_err++; $display("FAIL mismatch_busy got=%0d exp=0", busy_cnt - busy0); end
    n_cmp++; if (got_wr.size() != 0) begin n_err++; $display("FAIL mismatch_no_write got=%0d exp=0", got_wr.size()); end
    i2c_start();
    write_byte(8'h84, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL mismatch_next_ack got=%b exp=1", ack); end
    i2c_stop();
  endtask

  task automatic test_wrap();
    logic ack;
    got_wr.delete();
    exp_wr.push_back({8'hFF, 8'h11});
    exp_wr.push_back({8'h00, 8'h22});
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    i2c_stop();
    n_cmp++; if (got_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL wrap_count got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && got_wr.size() > 0) begin
      logic [15:0] e, g;
      e = exp_wr.pop_front();
      g = got_wr.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL wrap_strobe got=%h exp=%h", g, e); end
    end
    exp_wr.delete();
  endtask

  task automatic test_abort_stop();
    logic ack, s;
    logic [3:0] nib = 4'b1010;
    got_wr.delete();
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h30, ack);
    for (int i = 3; i >= 0; i--) xfer_bit(nib[i], s);
    i2c_stop();
    n_cmp++; if (got_wr.size() != 0) begin n_err++; $display("FAIL abort_no_write got=%0d exp=0", got_wr.size()); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL abort_state got=%0d exp=%0d", dut.state_q, IDLE); end
    n_cmp++; if (rif.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", rif.busy); end
  endtask

  task automatic test_reset_rdata();
    logic ack;
    mem[8'h40] = 8'h00;
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h40, ack);
    i2c_rstart();
    write_byte(8'h85, ack);
    wait_clk(Q);
    n_cmp++; if (sda !== 1'b0) begin n_err++; $display("FAIL rst_rdata_driving got=%b exp=0", sda); end
    rst = 1'b1;
    wait_clk(1);
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rst_rdata_release got=%b exp=1", sda); end
    n_cmp++; if (rif.busy !== 1'b0) begin n_err++; $display("FAIL rst_rdata_busy got=%b exp=0", rif.busy); end
    n_cmp++; if (rif.addr !== 8'h00) begin n_err++; $display("FAIL rst_rdata_addr got=%h exp=00", rif.addr); end
    n_cmp++; if (rif.wr_data !== 8'h00) begin n_err++; $display("FAIL rst_rdata_wr_data got=%h exp=00", rif.wr_data); end
    n_cmp++; if (rif.wr_en !== 1'b0 || rif.rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rdata_strobes got=%b%b exp=00", rif.wr_en, rif.rd_en); end
    wait_clk(2);
    rst = 1'b0;
    scl_r = 1'b1;
    wait_clk(2 * Q);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_abort_stop();
    test_reset_rdata();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
